// File: rtl/mem_line_arbiter_if.sv
// Client-side and SDRAM-side signals of the line arbiter, bundled with master/slave views.
// The arbiter uses the slave modport; whoever drives clients and the SDRAM model uses master.
interface mem_line_arbiter_if #(
  parameter int channels       = 4,
  parameter int addr_width     = 24,
  parameter int line_width     = 128,
  parameter int bus_width      = 16,
  parameter int mem_addr_width = 27
);
  logic [channels-1:0]            req_valid_i;
  logic [channels-1:0]            req_we_i;
  logic [channels*addr_width-1:0] req_addr_i;
  logic [channels*line_width-1:0] req_wdata_i;
  logic [channels-1:0]            req_ready_o;
  logic [channels-1:0]            resp_valid_o;
  logic [line_width-1:0]          resp_rdata_o;
  logic                           busy_o;
  logic                           mem_enabled_i;
  logic                           mem_data_ready_i;
  logic [mem_addr_width-1:0]      mem_addr_o;
  logic                           mem_r_valid_o;
  logic                           mem_w_valid_o;
  logic [bus_width-1:0]           mem_write_o;
  logic                           mem_r_valid_i;
  logic [bus_width-1:0]           mem_read_i;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    input  mem_enabled_i, mem_data_ready_i, mem_r_valid_i, mem_read_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, busy_o,
    output mem_addr_o, mem_r_valid_o, mem_w_valid_o, mem_write_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
    output mem_enabled_i, mem_data_ready_i, mem_r_valid_i, mem_read_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, busy_o,
    input  mem_addr_o, mem_r_valid_o, mem_w_valid_o, mem_write_o
  );
endinterface

// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter moving whole cache lines to/from the SDRAM controller as bus-width blocks.
// Write completes B+1 cycles after accept; block issue stalls on mem_data_ready_i, no grant while busy.
module mem_line_arbiter #(
  parameter int channels       = 4,
  parameter int addr_width     = 24,
  parameter int line_width     = 128,
  parameter int bus_width      = 16,
  parameter int mem_addr_width = 27
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  mem_line_arbiter_if.slave     bus
);

  localparam int B   = line_width / bus_width;
  localparam int LB  = $clog2(B);
  localparam int CW  = LB + 1;
  localparam int IW  = (LB > 0) ? LB : 1;
  localparam int CHW = (channels > 1) ? $clog2(channels) : 1;

  if (channels < 1) begin : g_chk_channels
    $error("mem_line_arbiter: channels must be at least 1");
  end
  if (line_width % bus_width != 0) begin : g_chk_div
    $error("mem_line_arbiter: line_width must be a multiple of bus_width");
  end
  if ((1 << LB) != B) begin : g_chk_pow2
    $error("mem_line_arbiter: blocks per line must be a power of two");
  end
  if (mem_addr_width != addr_width + LB) begin : g_chk_addr
    $error("mem_line_arbiter: mem_addr_width must equal addr_width + log2(blocks)");
  end

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           issued, received;
  logic [CHW-1:0]          last_grant, cur_ch;
  logic [CHW-1:0]          grant_ch, cand;
  logic                    grant_vld;
  logic                    cur_we;
  logic [addr_width-1:0]   cur_addr;
  logic [line_width-1:0]   line_buf, resp_hold, resp_line;
  logic [IW-1:0]           iss_idx, rcv_idx;
  logic                    issue, store, xfer;

  // Rotating search starting just after the last winner; only offered in IDLE with memory up.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    cand      = '0;
    if (state == IDLE && bus.mem_enabled_i) begin
      for (int i = 0; i < channels; i++) begin
        cand = CHW'((int'(last_grant) + 1 + i) % channels);
        if (!grant_vld && bus.req_valid_i[cand]) begin
          grant_vld = 1'b1;
          grant_ch  = cand;
        end
      end
    end
  end

  assign iss_idx = IW'(issued);
  assign rcv_idx = IW'(received);
  assign xfer    = (state == WRITE) || (state == READ);
  assign issue   = xfer && bus.mem_data_ready_i && (issued < CW'(B));
  assign store   = (state == READ) && bus.mem_r_valid_i && (received < CW'(B));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nxt = bus.req_we_i[grant_ch] ? WRITE : READ;
        end
      end
      WRITE: begin
        if (issue && issued == CW'(B - 1)) begin
          state_nxt = DONE;
        end
      end
      READ: begin
        if (store && received == CW'(B - 1)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Writes report an all-zero line; the last reported line is held between completions.
  assign resp_line = cur_we ? '0 : line_buf;

  assign bus.req_ready_o   = grant_vld ? (channels'(1) << grant_ch) : '0;
  assign bus.resp_valid_o  = (state == DONE) ? (channels'(1) << cur_ch) : '0;
  assign bus.resp_rdata_o  = (state == DONE) ? resp_line : resp_hold;
  assign bus.busy_o        = (state != IDLE);
  assign bus.mem_w_valid_o = issue && (state == WRITE);
  assign bus.mem_r_valid_o = issue && (state == READ);
  assign bus.mem_write_o   = (state == WRITE) ? line_buf[iss_idx*bus_width +: bus_width] : '0;
  assign bus.mem_addr_o    = xfer ? ((mem_addr_width'(cur_addr) << LB) + mem_addr_width'(issued)) : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      issued     <= '0;
      received   <= '0;
      last_grant <= CHW'(channels - 1);
      cur_ch     <= '0;
      cur_we     <= 1'b0;
      cur_addr   <= '0;
      line_buf   <= '0;
      resp_hold  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_vld) begin
        cur_ch     <= grant_ch;
        last_grant <= grant_ch;
        cur_we     <= bus.req_we_i[grant_ch];
        cur_addr   <= bus.req_addr_i[grant_ch*addr_width +: addr_width];
        line_buf   <= bus.req_wdata_i[grant_ch*line_width +: line_width];
      end
      if (issue) begin
        issued <= issued + CW'(1);
      end
      // Returns arrive in issue order, so the receive count is the block index.
      if (store) begin
        line_buf[rcv_idx*bus_width +: bus_width] <= bus.mem_read_i;
        received <= received + CW'(1);
      end
      if (state == DONE) begin
        issued    <= '0;
        received  <= '0;
        resp_hold <= resp_line;
      end
    end
  end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench for mem_line_arbiter: grant table, write/read line transfers, stalls, enable and reset.
module tb_mem_line_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_line_arbiter_if #(.channels(4), .addr_width(24), .line_width(128),
                        .bus_width(16), .mem_addr_width(27)) bus ();

  mem_line_arbiter #(.channels(4), .addr_width(24), .line_width(128),
                     .bus_width(16), .mem_addr_width(27)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // SDRAM model: each read command returns two cycles later with block k = k*0x1111.
  logic        p0_v = 1'b0, p1_v = 1'b0, p2_v = 1'b0;
  logic [26:0] p0_a = '0, p1_a = '0, p2_a = '0;
  always @(negedge clk) begin
    p2_v = p1_v; p2_a = p1_a;
    p1_v = p0_v; p1_a = p0_a;
    p0_v = bus.mem_r_valid_o; p0_a = bus.mem_addr_o;
    bus.mem_r_valid_i = p2_v;
    bus.mem_read_i    = p2_v ? 16'(p2_a[2:0]) * 16'h1111 : 16'h0;
  end

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       en;
    logic [3:0] exp_ready;
  } vec_t;

  localparam logic [127:0] READ_LINE = 128'h7777_6666_5555_4444_3333_2222_1111_0000;

  task automatic run_read(input int ch, input logic [23:0] addr, input logic [127:0] exp);
    int n, ncmd;
    bit got;
    bus.req_valid_i = 4'(1 << ch);
    bus.req_we_i    = 4'h0;
    bus.req_addr_i[ch*24 +: 24] = addr;
    bus.mem_data_ready_i = 1'b1;
    @(negedge clk);
    check($sformatf("rd%0d_grant", ch), bus.req_ready_o, 4'(1 << ch));
    next_cycle();
    bus.req_valid_i = 4'h0;
    n = 0; ncmd = 0; got = 0;
    while (!got && n < 30) begin
      n++;
      @(negedge clk);
      if (bus.mem_r_valid_o) begin
        check($sformatf("rd%0d_addr%0d", ch, ncmd), bus.mem_addr_o, {addr, 3'(ncmd)});
        ncmd++;
      end
      if (bus.resp_valid_o != 0) begin
        got = 1;
        check($sformatf("rd%0d_resp_ch", ch), bus.resp_valid_o, 4'(1 << ch));
        check($sformatf("rd%0d_rdata", ch), bus.resp_rdata_o, exp);
        check($sformatf("rd%0d_latency", ch), n, 11);
      end
      next_cycle();
    end
    check($sformatf("rd%0d_resp_seen", ch), got, 1);
    check($sformatf("rd%0d_cmd_count", ch), ncmd, 8);
    @(negedge clk);
    check($sformatf("rd%0d_rdata_hold", ch), bus.resp_rdata_o, exp);
    check($sformatf("rd%0d_resp_single", ch), bus.resp_valid_o, 4'h0);
    next_cycle();
  endtask

  initial begin
    vec_t        tbl[12];
    logic [15:0] wexp[8];
    logic [127:0] tline;
    int n, ncmd, extra, rcnt;
    bit got;

    tbl[0]  = '{4'b0000, 1'b1, 4'b0000};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0000};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0010};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0100};
    tbl[5]  = '{4'b1111, 1'b1, 4'b1000};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[7]  = '{4'b1001, 1'b1, 4'b1000};
    tbl[8]  = '{4'b0110, 1'b1, 4'b0010};
    tbl[9]  = '{4'b0010, 1'b1, 4'b0010};
    tbl[10] = '{4'b0001, 1'b1, 4'b0001};
    tbl[11] = '{4'b1110, 1'b1, 4'b0010};
    wexp = '{16'hEEFF, 16'hCCDD, 16'hAABB, 16'h8899, 16'h6677, 16'h4455, 16'h2233, 16'h0011};

    rst_n = 1'b0;
    bus.req_valid_i = '0; bus.req_we_i = '0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    bus.mem_enabled_i = 1'b0; bus.mem_data_ready_i = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_ready", bus.req_ready_o, 0);
    check("rst_resp_valid", bus.resp_valid_o, 0);
    check("rst_rdata", bus.resp_rdata_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_mem_cmds", {bus.mem_r_valid_o, bus.mem_w_valid_o, bus.mem_addr_o, bus.mem_write_o}, 0);
    next_cycle();
    rst_n = 1'b1;

    // Grant table: all rows issue writes, held valid until their completion.
    for (int i = 0; i < 12; i++) begin
      bus.req_valid_i = tbl[i].valid;
      bus.mem_enabled_i = tbl[i].en;
      bus.mem_data_ready_i = 1'b1;
      bus.req_we_i = 4'hF;
      @(negedge clk);
      check($sformatf("tbl%0d_grant", i), bus.req_ready_o, tbl[i].exp_ready);
      if (tbl[i].exp_ready == 0) begin
        check($sformatf("tbl%0d_no_cmd", i), {bus.mem_w_valid_o, bus.mem_r_valid_o, bus.busy_o}, 0);
      end
      next_cycle();
      if (tbl[i].exp_ready != 0) begin
        n = 0; got = 0; extra = 0;
        while (!got && n < 20) begin
          n++;
          @(negedge clk);
          if (bus.req_ready_o != 0) extra++;
          if (bus.resp_valid_o != 0) begin
            got = 1;
            check($sformatf("tbl%0d_resp_ch", i), bus.resp_valid_o, tbl[i].exp_ready);
            check($sformatf("tbl%0d_wr_rdata_zero", i), bus.resp_rdata_o, 0);
            check($sformatf("tbl%0d_latency", i), n, 9);
          end
          next_cycle();
        end
        check($sformatf("tbl%0d_resp_seen", i), got, 1);
        check($sformatf("tbl%0d_no_grant_busy", i), extra, 0);
      end
    end
    bus.req_valid_i = 4'h0;
    next_cycle();

    // ch1 writes a known line to 0x10 with memory always ready.
    bus.req_valid_i = 4'b0010;
    bus.req_we_i = 4'b0010;
    bus.req_addr_i[24 +: 24] = 24'h10;
    bus.req_wdata_i[128 +: 128] = 128'h00112233445566778899AABBCCDDEEFF;
    @(negedge clk);
    check("wr_grant", bus.req_ready_o, 4'b0010);
    next_cycle();
    bus.req_valid_i = 4'h0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        check($sformatf("wr_wvalid%0d", k), bus.mem_w_valid_o, 1);
        check($sformatf("wr_addr%0d", k), bus.mem_addr_o, 27'h80 + 27'(k - 1));
        check($sformatf("wr_data%0d", k), bus.mem_write_o, wexp[k-1]);
        check($sformatf("wr_noresp%0d", k), bus.resp_valid_o, 0);
      end else begin
        check("wr_done_wvalid", bus.mem_w_valid_o, 0);
        check("wr_resp", bus.resp_valid_o, 4'b0010);
      end
      next_cycle();
    end

    run_read(2, 24'h3, READ_LINE);

    // ch3 write with mem_data_ready_i toggling 1,0,1,0 from the first transfer cycle.
    for (int k = 0; k < 8; k++) tline[k*16 +: 16] = 16'hA000 + 16'(k);
    bus.req_valid_i = 4'b1000;
    bus.req_we_i = 4'b1000;
    bus.req_addr_i[72 +: 24] = 24'h5;
    bus.req_wdata_i[384 +: 128] = tline;
    @(negedge clk);
    check("tg_grant", bus.req_ready_o, 4'b1000);
    next_cycle();
    bus.req_valid_i = 4'h0;
    n = 0; ncmd = 0; got = 0;
    while (!got && n < 40) begin
      n++;
      bus.mem_data_ready_i = n[0];
      @(negedge clk);
      if (bus.mem_w_valid_o) begin
        check($sformatf("tg_on_ready%0d", ncmd), bus.mem_data_ready_i, 1);
        check($sformatf("tg_addr%0d", ncmd), bus.mem_addr_o, 27'h28 + 27'(ncmd));
        check($sformatf("tg_data%0d", ncmd), bus.mem_write_o, 16'hA000 + 16'(ncmd));
        ncmd++;
      end
      if (bus.resp_valid_o != 0) begin
        got = 1;
        check("tg_resp", bus.resp_valid_o, 4'b1000);
        check("tg_latency", n, 16);
      end
      next_cycle();
    end
    check("tg_resp_seen", got, 1);
    check("tg_cmd_count", ncmd, 8);
    bus.mem_data_ready_i = 1'b1;

    // Memory not enabled: requests wait; enabling grants ch0, then reset mid-read.
    bus.mem_enabled_i = 1'b0;
    bus.req_valid_i = 4'b0001;
    bus.req_we_i = 4'h0;
    bus.req_addr_i[0 +: 24] = 24'h7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("en0_ready%0d", k), bus.req_ready_o, 0);
      check($sformatf("en0_idle%0d", k), {bus.mem_w_valid_o, bus.mem_r_valid_o, bus.busy_o}, 0);
      next_cycle();
    end
    bus.mem_enabled_i = 1'b1;
    @(negedge clk);
    check("en1_grant", bus.req_ready_o, 4'b0001);
    next_cycle();
    bus.req_valid_i = 4'h0;
    repeat (5) next_cycle();
    @(negedge clk);
    check("rst_mid_busy", bus.busy_o, 1);
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("rstm_ready", bus.req_ready_o, 0);
    check("rstm_resp_valid", bus.resp_valid_o, 0);
    check("rstm_rdata", bus.resp_rdata_o, 0);
    check("rstm_busy", bus.busy_o, 0);
    check("rstm_mem_cmds", {bus.mem_r_valid_o, bus.mem_w_valid_o, bus.mem_addr_o, bus.mem_write_o}, 0);
    next_cycle();
    rcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.resp_valid_o != 0 || bus.busy_o) rcnt++;
      next_cycle();
    end
    check("rstm_no_resp", rcnt, 0);

    run_read(0, 24'h3, READ_LINE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
- Multi-channel successor to the single-port line memory controller.
- Accepts whole-line read/write requests from `channels` clients, picks one by round-robin, and moves the line to/from the SDRAM controller as `line_width/bus_width` bus-width blocks.
- Sits between the per-unit caches (line side) and `sdram_ctrl` (word side); one line transaction in flight at a time.

Parameters:
- channels, 4, number of requesting clients (>=1)
- addr_width, 24, width of a line address
- line_width, 128, bits per cache line
- bus_width, 16, bits per SDRAM block; line_width % bus_width == 0; blocks B = line_width/bus_width must be a power of two (elaboration assertions)
- mem_addr_width, 27, block address width; must equal addr_width + log2(B)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_valid_i  in  channels  per-channel request valid, held until accepted
- req_we_i  in  channels  1 = write line, 0 = read line
- req_addr_i  in  channels*addr_width  line address, channel i at slice i
- req_wdata_i  in  channels*line_width  write line, channel i at slice i
- req_ready_o  out  channels  one-hot accept strobe
- resp_valid_o  out  channels  one-cycle completion pulse per channel
- resp_rdata_o  out  line_width  read line, valid with resp_valid_o
- busy_o  out  1  state != IDLE
- mem_enabled_i  in  1  SDRAM controller initialised
- mem_data_ready_i  in  1  SDRAM controller can take a block command this cycle
- mem_addr_o  out  mem_addr_width  block address
- mem_r_valid_o  out  1  block read command
- mem_w_valid_o  out  1  block write command
- mem_write_o  out  bus_width  block write data
- mem_r_valid_i  in  1  returned block valid; returns are in issue order
- mem_read_i  in  bus_width  returned block data

Behaviour:
- Reset (rst_ni=0 at posedge):
  - state=IDLE; issue/receive counters=0; last_grant=channels-1, so channel 0 wins first.
  - All outputs 0. In-flight transaction abandoned, no response.
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - If mem_enabled_i=1 and any req_valid_i is set, req_ready_o is one-hot on the first valid channel searching from last_grant+1 with wrap-around; otherwise req_ready_o=0. This is combinational.
  - On accept, register channel, we, addr and wdata. Set last_grant=channel. Next state is WRITE if we, else READ.
- WRITE:
  - mem_w_valid_o = mem_data_ready_i & (issued < B).
  - mem_write_o = block[issued]; block 0 = line LSBs.
  - mem_addr_o = addr*B + issued.
  - issued increments on each mem_w_valid_o. After block B-1 is issued, go to DONE.
- READ:
  - mem_r_valid_o = mem_data_ready_i & (issued < B); same address rule; issued increments on each command.
  - Each mem_r_valid_i stores mem_read_i into block[received]; received increments.
  - When block B-1 is received, go to DONE. Issue and receive may overlap.
- DONE:
  - resp_valid_o[channel]=1 for exactly one cycle.
  - For reads, resp_rdata_o=assembled line; for writes, resp_rdata_o=0.
  - Counters clear; next state IDLE.
- resp_rdata_o holds its value until the next DONE.
- Counters are log2(B)+1 bits wide, so no wrap at B.
- mem_r_valid_i outside READ, or beyond B returns, is ignored.
- mem_enabled_i falling mid-transaction: no abort; issue stalls only through mem_data_ready_i.
- No grant in DONE, so there is a minimum one-cycle gap between back-to-back requests.
- A requester dropping req_valid_i before accept is legal; no effect.
- channels=1: grant is always channel 0.
- Latency with mem_data_ready_i held 1:
  - Write: accept at T, blocks at T+1..T+B, resp_valid_o at T+B+1.
  - Read: resp_valid_o one cycle after the last block returns.

Test Plan:
- Defaults; ch1 writes 0x00112233445566778899AABBCCDDEEFF to addr 0x10, data_ready=1 -> 8 mem_w_valid_o pulses, addrs 0x80..0x87, data 0xEEFF, 0xCCDD, ... 0x0011; resp_valid_o[1] 9 cycles after accept.
- ch2 reads addr 0x3, memory model has latency 2 and returns block k = k*0x1111 -> mem addrs 0x18..0x1F; resp_rdata_o = 0x7777666655554444333322221111 0000 with 0000 at LSBs; only resp_valid_o[2] pulses.
- All 4 channels hold req_valid_i continuously -> grant order 0,1,2,3,0; no channel granted twice before the others; each grant exactly one cycle.
- mem_data_ready_i toggling 1,0,1,0 during a write -> exactly 8 commands, only on ready cycles, addresses consecutive, no duplicates or skips.
- mem_enabled_i=0 with requests pending -> req_ready_o=0 and no mem commands; raise enable -> channel 0 granted next cycle.
- rst_ni low for one cycle in READ after 3 blocks returned -> all outputs 0, no resp_valid_o; a new read then completes correctly with counters starting at 0.
